// File: rtl/rwsb_bridge.sv
// rwsb_bridge: turns one-cycle pws/prs strobes into a held upwr/uprd request toward the register space.
// Optional timeout/abort logic (counter, tout, TODAT substitution) is built when RWSB_TOUT_EN is defined.
module rwsb_bridge #(
    parameter int unsigned AW    = 12,
    parameter int unsigned DW    = 16,
    parameter int unsigned TOW   = 8,
    parameter logic [15:0] TODAT = 16'hDEAD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pws,
    input  logic          prs,
    input  logic          pcesyn_,
    input  logic [AW-1:0] paddr,
    input  logic [DW-1:0] pdi,
    output logic [DW-1:0] pdo,
    output logic          pbusy,
    output logic [AW-1:0] upa,
    output logic [DW-1:0] upwdat,
    output logic          upwr,
    output logic          uprd,
    input  logic          upack,
    input  logic [DW-1:0] uprdat,
    output logic          tout,
    input  logic          toclr,
    output logic          drop
);

    typedef enum logic [1:0] {IDLE, WREQ, RREQ, HOLD} state_t;

    state_t        state_q;
    logic [DW-1:0] pdo_q;
    logic [DW-1:0] upwdat_q;
    logic [AW-1:0] upa_q;
    logic          upwr_q;
    logic          uprd_q;
    logic          pbusy_q;
    logic          drop_q;
    logic          strobe_d;

    assign strobe_d = pws | prs;

`ifdef RWSB_TOUT_EN
    // Last count value before abort: request stays up for 2**TOW-1 cycles.
    localparam logic [TOW-1:0] CNT_LAST = TOW'((2 ** TOW) - 2);
    localparam logic [DW-1:0]  TO_DATA  = DW'(TODAT);

    logic [TOW-1:0] cnt_q;
    logic           tout_q;

    assign tout = tout_q;
`else
    localparam int unsigned   unused_tow   = TOW;
    localparam logic [15:0]   unused_todat = TODAT;

    logic unused_toclr;

    assign unused_toclr = toclr;
    assign tout         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pdo_q    <= '0;
            upa_q    <= '0;
            upwdat_q <= '0;
            upwr_q   <= 1'b0;
            uprd_q   <= 1'b0;
            pbusy_q  <= 1'b0;
            drop_q   <= 1'b0;
`ifdef RWSB_TOUT_EN
            cnt_q    <= '0;
            tout_q   <= 1'b0;
`endif
        end else begin
            drop_q <= 1'b0;
`ifdef RWSB_TOUT_EN
            if (toclr) tout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (pws) begin
                        upa_q    <= paddr;
                        upwdat_q <= pdi;
                        upwr_q   <= 1'b1;
                        pbusy_q  <= 1'b1;
                        state_q  <= WREQ;
                    end else if (prs) begin
                        upa_q   <= paddr;
                        uprd_q  <= 1'b1;
                        pbusy_q <= 1'b1;
                        state_q <= RREQ;
                    end
`ifdef RWSB_TOUT_EN
                    cnt_q <= '0;
`endif
                end
                WREQ, RREQ: begin
                    drop_q <= strobe_d;
`ifdef RWSB_TOUT_EN
                    cnt_q <= cnt_q + 1'b1;
`endif
                    if (upack) begin
                        upwr_q  <= 1'b0;
                        uprd_q  <= 1'b0;
                        state_q <= HOLD;
                        if (state_q == RREQ) pdo_q <= uprdat;
                    end
`ifdef RWSB_TOUT_EN
                    else if (cnt_q == CNT_LAST) begin
                        upwr_q  <= 1'b0;
                        uprd_q  <= 1'b0;
                        tout_q  <= 1'b1;
                        state_q <= HOLD;
                        if (state_q == RREQ) pdo_q <= TO_DATA;
                    end
`endif
                end
                HOLD: begin
                    // Wait for chip enable release so one CE cycle yields one access.
                    drop_q <= strobe_d;
                    if (pcesyn_) begin
                        pbusy_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pdo    = pdo_q;
    assign upa    = upa_q;
    assign upwdat = upwdat_q;
    assign upwr   = upwr_q;
    assign uprd   = uprd_q;
    assign pbusy  = pbusy_q;
    assign drop   = drop_q;

endmodule

// File: tb/tb_rwsb_bridge.sv
// tb_rwsb_bridge: randomized self-checking bench for rwsb_bridge.
// Timeout scenarios are compiled in when RWSB_TOUT_EN is defined (DUT built with TOW=4).
module tb_rwsb_bridge;

    localparam int AW    = 12;
    localparam int DW    = 16;
    localparam int TOW   = 4;
    localparam int TOMAX = (2 ** TOW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pws = 1'b0;
    logic          prs = 1'b0;
    logic          pcesyn_ = 1'b1;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pdi = '0;
    logic [DW-1:0] pdo;
    logic          pbusy;
    logic [AW-1:0] upa;
    logic [DW-1:0] upwdat;
    logic          upwr;
    logic          uprd;
    logic          upack = 1'b0;
    logic [DW-1:0] uprdat = '0;
    logic          tout;
    logic          toclr = 1'b0;
    logic          drop;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] exp_pdo;
    logic          exp_tout;

    rwsb_bridge #(
        .AW(AW), .DW(DW), .TOW(TOW), .TODAT(16'hDEAD)
    ) dut (
        .clk(clk), .rst(rst), .pws(pws), .prs(prs), .pcesyn_(pcesyn_),
        .paddr(paddr), .pdi(pdi), .pdo(pdo), .pbusy(pbusy), .upa(upa),
        .upwdat(upwdat), .upwr(upwr), .uprd(uprd), .upack(upack),
        .uprdat(uprdat), .tout(tout), .toclr(toclr), .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    // Drive one access; ack on the n-th request cycle (n=0: never). Returns request-high cycle count.
    task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int n, input int maxc, output int hi);
        pcesyn_ = 1'b0;
        paddr = a;
        pdi = wr ? d : DW'($urandom);
        if (wr) pws = 1'b1;
        else prs = 1'b1;
        step();
        pws = 1'b0;
        prs = 1'b0;
        hi = 0;
        for (int c = 0; c < maxc; c++) begin
            if (upwr !== 1'b1 && uprd !== 1'b1) break;
            hi++;
            uprdat = DW'($urandom);
            if (hi == n) begin
                upack = 1'b1;
                uprdat = d;
            end
            step();
            upack = 1'b0;
        end
    endtask

    task automatic release_ce();
        pcesyn_ = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (pdo !== 16'h0) begin
            failures++; $display("FAIL reset_pdo got=%h exp=0000", pdo);
        end
        checks++;
        if ({upa, upwdat} !== 28'h0) begin
            failures++; $display("FAIL reset_regs got=%h/%h exp=0", upa, upwdat);
        end
        checks++;
        if ({upwr, uprd, pbusy, tout, drop} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000", {upwr, uprd, pbusy, tout, drop});
        end
        rst = 1'b0;
        step();
        exp_pdo = '0;
        exp_tout = 1'b0;
    endtask

    task automatic test_write();
        int hi;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int n;
        for (int i = 0; i < 5; i++) begin
            a = (i == 0) ? 12'h123 : AW'($urandom);
            d = (i == 0) ? 16'hA5A5 : DW'($urandom);
            n = (i == 0) ? 3 : int'($urandom_range(1, 12));
            xfer(1'b1, a, d, n, 2000, hi);
            checks++;
            if (hi !== n) begin
                failures++; $display("FAIL wr_len got=%0d exp=%0d", hi, n);
            end
            checks++;
            if (upa !== a || upwdat !== d) begin
                failures++; $display("FAIL wr_regs got=%h/%h exp=%h/%h", upa, upwdat, a, d);
            end
            checks++;
            if (pbusy !== 1'b1 || pdo !== exp_pdo) begin
                failures++; $display("FAIL wr_hold got=%b/%h exp=1/%h", pbusy, pdo, exp_pdo);
            end
            release_ce();
            checks++;
            if (pbusy !== 1'b0) begin
                failures++; $display("FAIL wr_release got=%b exp=0", pbusy);
            end
        end
    endtask

    task automatic test_read();
        int hi;
        xfer(1'b0, 12'h040, 16'h1234, 5, 2000, hi);
        exp_pdo = 16'h1234;
        checks++;
        if (hi !== 5) begin
            failures++; $display("FAIL rd_len got=%0d exp=5", hi);
        end
        checks++;
        if (pdo !== exp_pdo || uprd !== 1'b0 || upa !== 12'h040) begin
            failures++; $display("FAIL rd_data got=%h/%b/%h exp=1234/0/040", pdo, uprd, upa);
        end
        release_ce();
        xfer(1'b1, AW'($urandom), DW'($urandom), 2, 2000, hi);
        release_ce();
        checks++;
        if (pdo !== exp_pdo) begin
            failures++; $display("FAIL rd_keep got=%h exp=%h", pdo, exp_pdo);
        end
    endtask

    task automatic test_busy();
        logic [DW-1:0] r;
        r = DW'($urandom);
        pcesyn_ = 1'b0;
        paddr = 12'h0AA;
        prs = 1'b1;
        step();
        paddr = 12'h055;
        step();
        prs = 1'b0;
        checks++;
        if (drop !== 1'b1 || upa !== 12'h0AA || uprd !== 1'b1) begin
            failures++; $display("FAIL busy_req got=%b/%h/%b exp=1/0aa/1", drop, upa, uprd);
        end
        step();
        checks++;
        if (drop !== 1'b0) begin
            failures++; $display("FAIL busy_pulse got=%b exp=0", drop);
        end
        upack = 1'b1;
        uprdat = r;
        step();
        upack = 1'b0;
        exp_pdo = r;
        checks++;
        if (pdo !== exp_pdo || uprd !== 1'b0) begin
            failures++; $display("FAIL busy_ack got=%h/%b exp=%h/0", pdo, uprd, exp_pdo);
        end
        prs = 1'b1;
        step();
        prs = 1'b0;
        checks++;
        if (drop !== 1'b1 || upa !== 12'h0AA || pbusy !== 1'b1 || uprd !== 1'b0) begin
            failures++;
            $display("FAIL busy_hold got=%b/%h/%b/%b exp=1/0aa/1/0", drop, upa, pbusy, uprd);
        end
        release_ce();
        upack = 1'b1;
        uprdat = ~r;
        step();
        upack = 1'b0;
        checks++;
        if (pbusy !== 1'b0 || pdo !== exp_pdo || drop !== 1'b0) begin
            failures++; $display("FAIL idle_ack got=%b/%h/%b exp=0/%h/0", pbusy, pdo, drop, exp_pdo);
        end
        pcesyn_ = 1'b0;
        paddr = 12'h3C3;
        pdi = 16'hBEEF;
        pws = 1'b1;
        prs = 1'b1;
        step();
        pws = 1'b0;
        prs = 1'b0;
        checks++;
        if ({upwr, uprd, drop} !== 3'b100 || upa !== 12'h3C3 || upwdat !== 16'hBEEF) begin
            failures++;
            $display("FAIL both_strobe got=%b/%h/%h exp=100/3c3/beef", {upwr, uprd, drop}, upa, upwdat);
        end
        upack = 1'b1;
        step();
        upack = 1'b0;
        release_ce();
        checks++;
        if (pdo !== exp_pdo || pbusy !== 1'b0) begin
            failures++; $display("FAIL both_done got=%h/%b exp=%h/0", pdo, pbusy, exp_pdo);
        end
    endtask

`ifdef RWSB_TOUT_EN
    task automatic test_timeout();
        int hi;
        logic [DW-1:0] r;
        xfer(1'b0, 12'h777, 16'h5555, 0, 2000, hi);
        exp_pdo = 16'hDEAD;
        exp_tout = 1'b1;
        checks++;
        if (hi !== TOMAX) begin
            failures++; $display("FAIL to_len got=%0d exp=%0d", hi, TOMAX);
        end
        checks++;
        if (pdo !== exp_pdo || tout !== exp_tout) begin
            failures++; $display("FAIL to_data got=%h/%b exp=dead/1", pdo, tout);
        end
        release_ce();
        toclr = 1'b1;
        step();
        toclr = 1'b0;
        exp_tout = 1'b0;
        checks++;
        if (tout !== exp_tout) begin
            failures++; $display("FAIL to_clr got=%b exp=0", tout);
        end
        r = DW'($urandom);
        xfer(1'b0, 12'h778, r, TOMAX, 2000, hi);
        exp_pdo = r;
        checks++;
        if (hi !== TOMAX || pdo !== exp_pdo || tout !== 1'b0) begin
            failures++;
            $display("FAIL to_race got=%0d/%h/%b exp=%0d/%h/0", hi, pdo, tout, TOMAX, exp_pdo);
        end
        release_ce();
    endtask
`else
    task automatic test_noack();
        int hi;
        logic [DW-1:0] r;
        r = DW'($urandom);
        xfer(1'b0, 12'h777, r, 0, 1000, hi);
        checks++;
        if (hi !== 1000 || uprd !== 1'b1 || tout !== 1'b0) begin
            failures++; $display("FAIL noack got=%0d/%b/%b exp=1000/1/0", hi, uprd, tout);
        end
        upack = 1'b1;
        uprdat = r;
        step();
        upack = 1'b0;
        exp_pdo = r;
        checks++;
        if (pdo !== exp_pdo || uprd !== 1'b0) begin
            failures++; $display("FAIL noack_end got=%h/%b exp=%h/0", pdo, uprd, exp_pdo);
        end
        release_ce();
    endtask
`endif

    task automatic test_reset_mid();
        int hi;
        pcesyn_ = 1'b0;
        paddr = 12'h9AB;
        pdi = 16'hC0DE;
        pws = 1'b1;
        step();
        pws = 1'b0;
        step();
        checks++;
        if (upwr !== 1'b1) begin
            failures++; $display("FAIL mid_req got=%b exp=1", upwr);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_pdo = '0;
        exp_tout = 1'b0;
        checks++;
        if (upwr !== 1'b0 || pbusy !== 1'b0 || pdo !== exp_pdo) begin
            failures++; $display("FAIL mid_rst got=%b/%b/%h exp=0/0/0000", upwr, pbusy, pdo);
        end
        xfer(1'b1, 12'h456, 16'h7890, 2, 2000, hi);
        checks++;
        if (hi !== 2 || upa !== 12'h456 || upwdat !== 16'h7890) begin
            failures++; $display("FAIL mid_new got=%0d/%h/%h exp=2/456/7890", hi, upa, upwdat);
        end
        release_ce();
    endtask

    task automatic test_random();
        int hi;
        int n;
        int exp_hi;
        bit wr;
        bit timed;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int i = 0; i < 12; i++) begin
            wr = 1'($urandom);
            a = AW'($urandom);
            d = DW'($urandom);
`ifdef RWSB_TOUT_EN
            n = int'($urandom_range(0, TOMAX + 1));
            timed = (n == 0) || (n > TOMAX);
`else
            n = int'($urandom_range(1, 20));
            timed = 1'b0;
`endif
            exp_hi = timed ? TOMAX : n;
            if (!wr) exp_pdo = timed ? 16'hDEAD : d;
            if (timed) exp_tout = 1'b1;
            xfer(wr, a, d, n, 2000, hi);
            checks++;
            if (hi !== exp_hi || upa !== a) begin
                failures++; $display("FAIL rnd_req%0d got=%0d/%h exp=%0d/%h", i, hi, upa, exp_hi, a);
            end
            checks++;
            if (pdo !== exp_pdo || tout !== exp_tout) begin
                failures++;
                $display("FAIL rnd_out%0d got=%h/%b exp=%h/%b", i, pdo, tout, exp_pdo, exp_tout);
            end
            if (wr) begin
                checks++;
                if (upwdat !== d) begin
                    failures++; $display("FAIL rnd_wdat%0d got=%h exp=%h", i, upwdat, d);
                end
            end
            release_ce();
            if (exp_tout) begin
                toclr = 1'b1;
                step();
                toclr = 1'b0;
                exp_tout = 1'b0;
                checks++;
                if (tout !== exp_tout) begin
                    failures++; $display("FAIL rnd_clr%0d got=%b exp=0", i, tout);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_busy();
`ifdef RWSB_TOUT_EN
        test_timeout();
`else
        test_noack();
`endif
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
